pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 pipeline. Replaces per-hazard ad-hoc enables with one prioritized controller.
- Combines four stall/flush sources into per-stage register enables and flushes:
  - data-memory wait (MEM stage)
  - multi-cycle M-extension ops (EX stage)
  - taken branch/jump (EX stage)
  - load-use hazard (ID stage)
- Counts stall and flush cycles for performance monitoring.

---
 rtl/pipeline_stall_controller_if.sv | 49 ++++
 rtl/pipeline_stall_controller.sv | 178 +++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and stage-control outputs exchanged between the RV32 pipeline
// and its central stall/flush controller.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 32
);
  logic             mem_read_ex;
  logic [4:0]       rd_ex;
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             pc_src_ex;
  logic             mdu_start_ex;
  logic             mdu_is_div_ex;
  logic             div_done;
  logic             dmem_req_mem;
  logic             dmem_ready;

  logic             mdu_go;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             mdu_busy;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: reports hazards, consumes enables/flushes.
  modport master (
    output mem_read_ex, rd_ex, rs1_id, rs2_id, pc_src_ex, mdu_start_ex,
           mdu_is_div_ex, div_done, dmem_req_mem, dmem_ready,
    input  mdu_go, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           mdu_busy, mem_timeout, stall_cycles, flush_count
  );

  // Controller side.
  modport slave (
    input  mem_read_ex, rd_ex, rs1_id, rs2_id, pc_src_ex, mdu_start_ex,
           mdu_is_div_ex, div_done, dmem_req_mem, dmem_ready,
    output mdu_go, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           mdu_busy, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Prioritised stall/flush sequencer for the 5-stage RV32 pipeline:
// dmem wait > MUL/DIV occupancy > taken branch > load-use hazard.
module pipeline_stall_controller #(
  parameter int MUL_LATENCY = 3,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic                        clk,
  input logic                        reset,
  pipeline_stall_controller_if.slave bus
);
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MDU_BUSY = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam int MUL_W  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [MUL_W-1:0]  MUL_INIT = MUL_W'(MUL_LATENCY - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        stateReg;
  logic [1:0]        stateNext;
  logic [MUL_W-1:0]  mulCntReg;
  logic              divSeenReg;
  logic [WAIT_W-1:0] waitCntReg;
  logic              memTimeoutReg;
  logic [CNT_W-1:0]  stallCyclesReg;
  logic [CNT_W-1:0]  flushCountReg;

  logic memStall;
  logic inRun;
  logic inMdu;
  logic mduEntry;
  logic mduComplete;
  logic mduHold;
  logic branchTake;
  logic loadUse;

  logic mduGo;
  logic pcEn;
  logic ifIdEn;
  logic idExEn;
  logic exMemEn;
  logic memWbEn;
  logic ifIdFlush;
  logic idExFlush;
  logic exMemFlush;
  logic memWbFlush;

  assign memStall    = bus.dmem_req_mem & ~bus.dmem_ready;
  assign inRun       = (stateReg == RUN);
  assign inMdu       = (stateReg == MDU_BUSY);
  assign mduEntry    = inRun & bus.mdu_start_ex & ~memStall;
  assign mduComplete = bus.mdu_is_div_ex ? (bus.div_done | divSeenReg)
                                         : (mulCntReg == '0);
  // EX is occupied by the MUL/DIV op: either the start cycle or an unfinished op.
  assign mduHold     = mduEntry | (inMdu & ~mduComplete & ~memStall);
  assign branchTake  = bus.pc_src_ex & ~memStall & ~mduHold;
  assign loadUse     = inRun & ~memStall & ~mduEntry & ~branchTake
                     & bus.mem_read_ex & (bus.rd_ex != 5'd0)
                     & ((bus.rd_ex == bus.rs1_id) | (bus.rd_ex == bus.rs2_id));

  always_comb begin
    mduGo      = 1'b0;
    pcEn       = 1'b1;
    ifIdEn     = 1'b1;
    idExEn     = 1'b1;
    exMemEn    = 1'b1;
    memWbEn    = 1'b1;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    exMemFlush = 1'b0;
    memWbFlush = 1'b0;
    if (reset) begin
      pcEn       = 1'b0;
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
      exMemFlush = 1'b1;
      memWbFlush = 1'b1;
    end else if (memStall) begin
      pcEn       = 1'b0;
      ifIdEn     = 1'b0;
      idExEn     = 1'b0;
      exMemEn    = 1'b0;
      memWbEn    = 1'b0;
      memWbFlush = 1'b1;
    end else if (mduHold) begin
      mduGo      = mduEntry;
      pcEn       = 1'b0;
      ifIdEn     = 1'b0;
      idExEn     = 1'b0;
      exMemFlush = 1'b1;
    end else if (branchTake) begin
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
    end else if (loadUse) begin
      pcEn       = 1'b0;
      ifIdEn     = 1'b0;
      idExFlush  = 1'b1;
    end
  end

  // A dmem wait freezes RUN into MEM_WAIT but leaves an MDU op in MDU_BUSY.
  always_comb begin
    stateNext = stateReg;
    if (memStall) begin
      if (!inMdu) begin
        stateNext = MEM_WAIT;
      end
    end else begin
      case (stateReg)
        RUN:      if (mduEntry) stateNext = MDU_BUSY;
        MDU_BUSY: if (mduComplete) stateNext = RUN;
        default:  stateNext = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg       <= RUN;
      mulCntReg      <= '0;
      divSeenReg     <= 1'b0;
      waitCntReg     <= '0;
      memTimeoutReg  <= 1'b0;
      stallCyclesReg <= '0;
      flushCountReg  <= '0;
    end else begin
      stateReg <= stateNext;

      if (mduEntry) begin
        mulCntReg  <= MUL_INIT;
        divSeenReg <= 1'b0;
      end else if (inMdu) begin
        if (mulCntReg != '0) begin
          mulCntReg <= mulCntReg - MUL_W'(1);
        end
        // Remember a div_done that lands while dmem holds the pipeline.
        if (bus.div_done) begin
          divSeenReg <= 1'b1;
        end
      end

      if (memStall) begin
        if (waitCntReg != WAIT_MAX) begin
          waitCntReg <= waitCntReg + WAIT_W'(1);
        end
        if (waitCntReg == WAIT_MAX) begin
          memTimeoutReg <= 1'b1;
        end
      end else begin
        waitCntReg <= '0;
      end

      if (!pcEn) begin
        stallCyclesReg <= stallCyclesReg + CNT_W'(1);
      end
      if (branchTake) begin
        flushCountReg <= flushCountReg + CNT_W'(1);
      end
    end
  end

  assign bus.mdu_go       = mduGo;
  assign bus.pc_en        = pcEn;
  assign bus.if_id_en     = ifIdEn;
  assign bus.id_ex_en     = idExEn;
  assign bus.ex_mem_en    = exMemEn;
  assign bus.mem_wb_en    = memWbEn;
  assign bus.if_id_flush  = ifIdFlush;
  assign bus.id_ex_flush  = idExFlush;
  assign bus.ex_mem_flush = exMemFlush;
  assign bus.mem_wb_flush = memWbFlush;
  assign bus.mdu_busy     = inMdu;
  assign bus.mem_timeout  = memTimeoutReg;
  assign bus.stall_cycles = stallCyclesReg;
  assign bus.flush_count  = flushCountReg;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scenarios plus randomized traffic for the stall controller, each
// cycle compared against a behavioural model of the hazard priority rules.
module tb_pipeline_stall_controller;
  localparam int MUL_LAT = 3;
  localparam int MEM_TO  = 4;
  localparam int CW      = 8;
  localparam int CMASK   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.CNT_W(CW)) bus ();

  pipeline_stall_controller #(
    .MUL_LATENCY(MUL_LAT),
    .MEM_TIMEOUT(MEM_TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit       rst;
    bit       memRead;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       pcSrc;
    bit       start;
    bit       isDiv;
    bit       divDone;
    bit       req;
    bit       ready;
  } stim_t;

  int compared   = 0;
  int mismatched = 0;

  // Model: an MDU op in flight with its age, the last cycle's dmem wait,
  // the current run of wait cycles, and the two perf counters.
  bit mInMdu;
  int mAge;
  bit mDivGot;
  bit mPrevStall;
  int mStreak;
  bit mTimeout;
  int mStallCnt;
  int mFlushCnt;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic modelClear();
    mInMdu     = 1'b0;
    mAge       = 0;
    mDivGot    = 1'b0;
    mPrevStall = 1'b0;
    mStreak    = 0;
    mTimeout   = 1'b0;
    mStallCnt  = 0;
    mFlushCnt  = 0;
  endtask

  task automatic runCycle(input stim_t s);
    bit stall, isRun, entry, done, hold, branch, lu;
    bit eGo, ePc, eIfId, eIdEx, eExMem, eMemWb, fIfId, fIdEx, fExMem, fMemWb;
    logic [11:0] expVec, gotVec;
    @(negedge clk);
    reset             = s.rst;
    bus.mem_read_ex   = s.memRead;
    bus.rd_ex         = s.rd;
    bus.rs1_id        = s.rs1;
    bus.rs2_id        = s.rs2;
    bus.pc_src_ex     = s.pcSrc;
    bus.mdu_start_ex  = s.start;
    bus.mdu_is_div_ex = s.isDiv;
    bus.div_done      = s.divDone;
    bus.dmem_req_mem  = s.req;
    bus.dmem_ready    = s.ready;
    #1;
    stall  = s.req && !s.ready;
    isRun  = !mInMdu && !mPrevStall;
    entry  = isRun && s.start && !stall;
    done   = mInMdu && (s.isDiv ? (s.divDone || mDivGot) : (mAge >= MUL_LAT));
    hold   = entry || (mInMdu && !done && !stall);
    branch = s.pcSrc && !stall && !hold;
    lu     = isRun && !stall && !entry && !branch && s.memRead && (s.rd != 0)
             && ((s.rd == s.rs1) || (s.rd == s.rs2));

    {eGo, ePc, eIfId, eIdEx, eExMem, eMemWb} = 6'b011111;
    {fIfId, fIdEx, fExMem, fMemWb} = 4'b0000;
    if (s.rst) begin
      ePc = 1'b0;
      {fIfId, fIdEx, fExMem, fMemWb} = 4'b1111;
    end else if (stall) begin
      {ePc, eIfId, eIdEx, eExMem, eMemWb} = 5'b00000;
      fMemWb = 1'b1;
    end else if (hold) begin
      eGo = entry;
      {ePc, eIfId, eIdEx} = 3'b000;
      fExMem = 1'b1;
    end else if (branch) begin
      {fIfId, fIdEx} = 2'b11;
    end else if (lu) begin
      {ePc, eIfId} = 2'b00;
      fIdEx = 1'b1;
    end

    expVec = {eGo, ePc, eIfId, eIdEx, eExMem, eMemWb,
              fIfId, fIdEx, fExMem, fMemWb, mInMdu, mTimeout};
    gotVec = {bus.mdu_go, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
              bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
              bus.mem_wb_flush, bus.mdu_busy, bus.mem_timeout};
    checkEq("ctrl", 32'(gotVec), 32'(expVec));
    checkEq("stall_cycles", 32'(bus.stall_cycles), mStallCnt);
    checkEq("flush_count", 32'(bus.flush_count), mFlushCnt);

    if (s.rst) begin
      modelClear();
    end else begin
      mStreak = stall ? mStreak + 1 : 0;
      if (mStreak >= MEM_TO) mTimeout = 1'b1;
      if (!ePc) mStallCnt = (mStallCnt + 1) & CMASK;
      if (branch) mFlushCnt = (mFlushCnt + 1) & CMASK;
      mPrevStall = stall && !mInMdu;
      if (mInMdu) begin
        mAge++;
        if (s.divDone) mDivGot = 1'b1;
        if (done && !stall) mInMdu = 1'b0;
      end else if (entry) begin
        mInMdu  = 1'b1;
        mAge    = 1;
        mDivGot = 1'b0;
      end
    end
  endtask

  task automatic doReset();
    stim_t s;
    s = idleStim();
    s.rst = 1'b1;
    runCycle(s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    bit curDiv;
    reset = 1'b1;
    bus.mem_read_ex = 0; bus.rd_ex = 0; bus.rs1_id = 0; bus.rs2_id = 0;
    bus.pc_src_ex = 0; bus.mdu_start_ex = 0; bus.mdu_is_div_ex = 0;
    bus.div_done = 0; bus.dmem_req_mem = 0; bus.dmem_ready = 0;
    repeat (2) @(posedge clk);
    modelClear();

    doReset();
    s = idleStim(); runCycle(s);
    checkEq("rst_stall_cycles", 32'(bus.stall_cycles), 0);
    checkEq("rst_busy", 32'(bus.mdu_busy), 0);

    // Load-use, then the same pattern with x0 as destination.
    s = idleStim(); s.memRead = 1; s.rd = 5; s.rs2 = 5; runCycle(s);
    checkEq("lu_pc_en", 32'(bus.pc_en), 0);
    checkEq("lu_id_ex_flush", 32'(bus.id_ex_flush), 1);
    s = idleStim(); runCycle(s);
    checkEq("lu_stall_cycles", 32'(bus.stall_cycles), 1);
    s = idleStim(); s.memRead = 1; runCycle(s);
    checkEq("lu_rd0_pc_en", 32'(bus.pc_en), 1);

    // Multiply held in EX.
    doReset();
    for (int c = 0; c < 4; c++) begin
      s = idleStim(); s.start = 1; runCycle(s);
      if (c == 0) checkEq("mul_go", 32'(bus.mdu_go), 1);
      if (c == 3) checkEq("mul_release", 32'(bus.pc_en), 1);
    end
    s = idleStim(); runCycle(s);
    checkEq("mul_busy_end", 32'(bus.mdu_busy), 0);
    checkEq("mul_stall_cycles", 32'(bus.stall_cycles), 3);

    // Divide with div_done landing inside a dmem wait.
    doReset();
    for (int c = 0; c < 10; c++) begin
      s = idleStim(); s.start = 1; s.isDiv = 1;
      s.req = (c >= 6 && c <= 8); s.divDone = (c == 7);
      runCycle(s);
      if (c == 8) checkEq("div_frozen", 32'(bus.mem_wb_en), 0);
      if (c == 9) checkEq("div_release", 32'(bus.pc_en), 1);
    end
    s = idleStim(); runCycle(s);
    checkEq("div_busy_end", 32'(bus.mdu_busy), 0);

    // Branch beats load-use.
    doReset();
    s = idleStim(); s.pcSrc = 1; s.memRead = 1; s.rd = 5; s.rs1 = 5; runCycle(s);
    checkEq("br_pc_en", 32'(bus.pc_en), 1);
    s = idleStim(); runCycle(s);
    checkEq("br_flush_count", 32'(bus.flush_count), 1);

    // Branch held across a two-cycle dmem wait.
    doReset();
    for (int c = 0; c < 3; c++) begin
      s = idleStim(); s.pcSrc = 1; s.memRead = 1; s.rd = 5; s.rs1 = 5;
      s.req = 1; s.ready = (c == 2);
      runCycle(s);
      if (c == 0) checkEq("brst_no_flush", 32'(bus.if_id_flush), 0);
    end
    s = idleStim(); runCycle(s);
    checkEq("brst_flush_count", 32'(bus.flush_count), 1);

    // Memory timeout.
    doReset();
    for (int c = 0; c < 6; c++) begin
      s = idleStim(); s.req = 1; runCycle(s);
      if (c == 3) checkEq("to_before", 32'(bus.mem_timeout), 0);
      if (c == 4) checkEq("to_set", 32'(bus.mem_timeout), 1);
    end
    s = idleStim(); runCycle(s);
    checkEq("to_sticky", 32'(bus.mem_timeout), 1);
    doReset();
    s = idleStim(); runCycle(s);
    checkEq("to_cleared", 32'(bus.mem_timeout), 0);

    // Reset while a multiply is in flight.
    doReset();
    s = idleStim(); s.start = 1; runCycle(s); runCycle(s);
    s.rst = 1; runCycle(s);
    s = idleStim(); runCycle(s);
    checkEq("rstmdu_busy", 32'(bus.mdu_busy), 0);
    checkEq("rstmdu_go", 32'(bus.mdu_go), 0);
    checkEq("rstmdu_stall_cycles", 32'(bus.stall_cycles), 0);

    // Random traffic; an MDU op keeps its EX instruction stable until it leaves.
    curDiv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      s = idleStim();
      if (!mInMdu) curDiv = 1'($urandom_range(0, 1));
      s.rst     = ($urandom_range(0, 63) == 0);
      s.memRead = 1'($urandom_range(0, 1));
      s.rd      = 5'($urandom_range(0, 3));
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2     = 5'($urandom_range(0, 3));
      s.isDiv   = curDiv;
      s.divDone = ($urandom_range(0, 3) == 0);
      s.req     = 1'($urandom_range(0, 1));
      s.ready   = ($urandom_range(0, 2) != 0);
      if (mInMdu) begin
        s.start = 1'b1;
      end else begin
        s.start = ($urandom_range(0, 5) == 0);
        s.pcSrc = !s.start && ($urandom_range(0, 4) == 0);
      end
      runCycle(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
